cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_pkg.sv | 26 ++
 rtl/sync_edge.sv | 32 +++
 rtl/cam_capture.sv | 197 +++++++++++++++++++
 tb/tb_cam_capture.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types for the camera capture block: FSM encoding and RGB565 pixel layout.
package cam_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWaitFrame = 2'd1,
        StCapture   = 2'd2
    } cam_state_e;

    localparam int unsigned R_W  = 5;
    localparam int unsigned G_W  = 6;
    localparam int unsigned B_W  = 5;
    localparam int unsigned PX_W = R_W + G_W + B_W;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

    // The camera sends the high byte (R and upper G) first.
    function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a third stage for rise/fall detection on the synchronized value.
module sync_edge #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] s2,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] s1_q, s2_q, s3_q;

    // Shift the asynchronous input through three stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign s2   = s2_q;
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/cam_capture.sv
// Samples a parallel camera bus in the system clock domain and assembles RGB565 pixels
// with frame/line coordinates for a downstream FIFO.
module cam_capture
    import cam_pkg::*;
#(
    parameter int unsigned H_PIXELS = 160,
    parameter int unsigned V_LINES  = 120
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        cam_pclk,
    input  logic                        cam_vsync,
    input  logic                        cam_href,
    input  logic [7:0]                  cam_d,
    input  logic                        fifo_full,
    output logic [PX_W-1:0]             px_data,
    output logic                        px_valid,
    output logic [$clog2(H_PIXELS)-1:0] px_x,
    output logic [$clog2(V_LINES)-1:0]  px_y,
    output logic                        frame_start,
    output logic                        frame_done,
    output logic                        overflow,
    output logic                        busy
);

    localparam int unsigned XW  = $clog2(H_PIXELS);
    localparam int unsigned YW  = $clog2(V_LINES);
    // Counters carry one extra code so they can saturate at the out-of-range value.
    localparam int unsigned XCW = $clog2(H_PIXELS + 1);
    localparam int unsigned YCW = $clog2(V_LINES + 1);
    localparam logic [XCW-1:0] XMAX = XCW'(H_PIXELS);
    localparam logic [YCW-1:0] YMAX = YCW'(V_LINES);

    logic       pclk_s2, pclk_rise, pclk_fall;
    logic       vsync_s2, vsync_rise, vsync_fall;
    logic       href_s2, href_rise, href_fall;
    logic [7:0] d_s2, d_rise, d_fall;

    sync_edge #(.WIDTH(1)) u_sync_pclk (
        .clk  (clk),
        .reset(reset),
        .d    (cam_pclk),
        .s2   (pclk_s2),
        .rise (pclk_rise),
        .fall (pclk_fall)
    );

    sync_edge #(.WIDTH(1)) u_sync_vsync (
        .clk  (clk),
        .reset(reset),
        .d    (cam_vsync),
        .s2   (vsync_s2),
        .rise (vsync_rise),
        .fall (vsync_fall)
    );

    sync_edge #(.WIDTH(1)) u_sync_href (
        .clk  (clk),
        .reset(reset),
        .d    (cam_href),
        .s2   (href_s2),
        .rise (href_rise),
        .fall (href_fall)
    );

    sync_edge #(.WIDTH(8)) u_sync_d (
        .clk  (clk),
        .reset(reset),
        .d    (cam_d),
        .s2   (d_s2),
        .rise (d_rise),
        .fall (d_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{pclk_s2, pclk_fall, href_rise, d_rise, d_fall};

    cam_state_e state_q, state_d;

    logic           phase_q, phase_d;
    logic [7:0]     hi_q, hi_d;
    rgb565_t        data_q, data_d;
    logic           pend_q, pend_d;
    logic [XCW-1:0] x_q, x_d;
    logic [YCW-1:0] y_q, y_d;
    logic           overflow_q, overflow_d;
    logic           in_range;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: arm on vsync high, capture between vsync falling and rising edges.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable && vsync_s2) state_d = StWaitFrame;
            end
            StWaitFrame: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (vsync_fall) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (vsync_rise) state_d = enable ? StWaitFrame : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: frame pulses mark the transition cycle itself.
    always_comb begin
        frame_start = (state_q != StCapture) && (state_d == StCapture);
        frame_done  = (state_q == StCapture) && (state_d != StCapture);
        busy        = (state_q == StWaitFrame) || (state_q == StCapture);
    end

    assign in_range = (x_q < XMAX) && (y_q < YMAX);

    // Pixel assembly, coordinate counters and sticky overflow.
    always_comb begin
        phase_d    = phase_q;
        hi_d       = hi_q;
        data_d     = data_q;
        pend_d     = 1'b0;
        x_d        = x_q;
        y_d        = y_q;
        overflow_d = overflow_q;

        // A pending pixel is written or dropped this cycle; either way the column advances.
        if (pend_q) begin
            if (x_q < XMAX) x_d = x_q + XCW'(1);
            if (in_range && fifo_full) overflow_d = 1'b1;
        end

        if (state_q == StCapture) begin
            if (href_fall) begin
                phase_d = 1'b0;
                x_d     = '0;
                if (y_q < YMAX) y_d = y_q + YCW'(1);
            end else if (pclk_rise && href_s2) begin
                if (!phase_q) begin
                    hi_d    = d_s2;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    data_d  = pack_rgb565(hi_q, d_s2);
                    pend_d  = 1'b1;
                end
            end
        end

        if (frame_start) begin
            phase_d    = 1'b0;
            x_d        = '0;
            y_d        = '0;
            overflow_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q    <= 1'b0;
            hi_q       <= '0;
            data_q     <= '0;
            pend_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            data_q     <= data_d;
            pend_q     <= pend_d;
            x_q        <= x_d;
            y_q        <= y_d;
            overflow_q <= overflow_d;
        end
    end

    assign px_valid = pend_q && in_range && !fifo_full;
    assign px_data  = data_q;
    assign px_x     = x_q[XW-1:0];
    assign px_y     = y_q[YW-1:0];
    assign overflow = overflow_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture using a small frame size and a clk/4 camera pixel clock.
module tb_cam_capture;

    localparam int H  = 10;
    localparam int V  = 6;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          cam_pclk;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_d;
    logic          fifo_full;
    logic [15:0]   px_data;
    logic          px_valid;
    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic          frame_start;
    logic          frame_done;
    logic          overflow;
    logic          busy;

    cam_capture #(
        .H_PIXELS(H),
        .V_LINES (V)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_d      (cam_d),
        .fifo_full  (fifo_full),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_x       (px_x),
        .px_y       (px_y),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] data;
        int          x;
        int          y;
        time         t;
    } px_rec_t;

    px_rec_t mon_q[$];
    int      n_fs = 0;
    int      n_fd = 0;

    // Monitor: sample just after the falling edge, well away from the active edge.
    always @(negedge clk) begin
        #1;
        if (px_valid) mon_q.push_back('{px_data, int'(px_x), int'(px_y), $time});
        if (frame_start) n_fs++;
        if (frame_done) n_fd++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required normal completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic px_rec_t rec_at(input int i);
        px_rec_t r;
        r = '{16'hxxxx, -1, -1, 0};
        if (i >= 0 && i < mon_q.size()) r = mon_q[i];
        return r;
    endfunction

    // Count captured pixels whose data does not match the {line, column} stimulus pattern.
    function automatic int pattern_errs();
        int errs = 0;
        foreach (mon_q[i]) begin
            if (mon_q[i].data !== {8'(mon_q[i].y), 8'(mon_q[i].x)}) errs++;
        end
        return errs;
    endfunction

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_d = b;
        clk_n(2);
        cam_pclk = 1'b1;
        clk_n(2);
        cam_pclk = 1'b0;
    endtask

    // One line of npairs pixels {y, k}; fifo_full covers pairs full_lo..full_hi.
    task automatic send_line(input int y, input int npairs, input int full_lo, input int full_hi);
        cam_href = 1'b1;
        for (int k = 0; k < npairs; k++) begin
            send_byte(8'(y));
            fifo_full = (k >= full_lo) && (k <= full_hi);
            send_byte(8'(k));
        end
        fifo_full = 1'b0;
        clk_n(2);
        cam_href = 1'b0;
        clk_n(6);
    endtask

    task automatic frame_begin();
        cam_vsync = 1'b0;
        clk_n(8);
    endtask

    task automatic frame_end();
        cam_vsync = 1'b1;
        clk_n(8);
    endtask

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];
    int   fs0, fd0;
    time  t0;
    int   gap_hits;

    initial begin
        vecs[0] = '{8'hF8, 8'h1F, 16'hF81F};
        vecs[1] = '{8'h00, 8'h00, 16'h0000};
        vecs[2] = '{8'hFF, 8'hFF, 16'hFFFF};
        vecs[3] = '{8'h12, 8'h34, 16'h1234};
        vecs[4] = '{8'hA5, 8'h5A, 16'hA55A};
        vecs[5] = '{8'h07, 8'hE0, 16'h07E0};

        reset     = 1'b0;
        enable    = 1'b0;
        cam_pclk  = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_d     = 8'h00;
        fifo_full = 1'b0;
        clk_n(3);
        #1;
        check("rst_px_data", 32'(px_data), 32'h0);
        check("rst_px_valid", 32'(px_valid), 32'h0);
        check("rst_px_x", 32'(px_x), 32'h0);
        check("rst_px_y", 32'(px_y), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Enabled but vsync still low: must stay idle.
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        clk_n(10);
        check("idle_without_vsync", 32'(busy), 32'h0);
        frame_end();
        check("wait_frame_busy", 32'(busy), 32'h1);

        // Full frame of the {line, column} ramp.
        mon_q.delete();
        fs0 = n_fs;
        fd0 = n_fd;
        frame_begin();
        for (int y = 0; y < V; y++) send_line(y, H, -1, -1);
        frame_end();
        check("frame_px_count", 32'(mon_q.size()), 32'(H * V));
        check("frame_first_data", 32'(rec_at(0).data), 32'h0);
        check("frame_first_xy", 32'({rec_at(0).x[15:0], rec_at(0).y[15:0]}), 32'h0);
        check("frame_last_xy", 32'({rec_at(H * V - 1).x[15:0], rec_at(H * V - 1).y[15:0]}),
              {16'(H - 1), 16'(V - 1)});
        check("frame_last_data", 32'(rec_at(H * V - 1).data), 32'({8'(V - 1), 8'(H - 1)}));
        check("frame_pattern", 32'(pattern_errs()), 32'h0);
        check("frame_start_count", 32'(n_fs - fs0), 32'h1);
        check("frame_done_count", 32'(n_fd - fd0), 32'h1);
        check("frame_no_overflow", 32'(overflow), 32'h0);

        // Byte-pair table: data assembly, column and write-strobe latency.
        mon_q.delete();
        frame_begin();
        cam_href = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].hi);
            cam_d = vecs[i].lo;
            clk_n(2);
            cam_pclk = 1'b1;
            t0 = $time;
            clk_n(2);
            cam_pclk = 1'b0;
            clk_n(2);
            check($sformatf("vec%0d_count", i), 32'(mon_q.size()), 32'(i + 1));
            check($sformatf("vec%0d_data", i), 32'(rec_at(i).data), 32'(vecs[i].exp));
            check($sformatf("vec%0d_x", i), 32'(rec_at(i).x), 32'(i));
            // pclk pin -> 2 sync flops -> edge event -> strobe one cycle later
            check($sformatf("vec%0d_latency", i), 32'(rec_at(i).t - t0), 32'd31);
        end
        clk_n(2);
        cam_href = 1'b0;
        clk_n(6);
        frame_end();

        // FIFO full across three pixel slots mid-line.
        mon_q.delete();
        frame_begin();
        send_line(0, H, 3, 5);
        check("ovf_px_count", 32'(mon_q.size()), 32'(H - 3));
        gap_hits = 0;
        foreach (mon_q[i]) if (mon_q[i].x >= 3 && mon_q[i].x <= 5) gap_hits++;
        check("ovf_gap_absent", 32'(gap_hits), 32'h0);
        check("ovf_x_skip", 32'(rec_at(3).x), 32'd6);
        check("ovf_pattern", 32'(pattern_errs()), 32'h0);
        check("ovf_set", 32'(overflow), 32'h1);
        frame_end();
        check("ovf_sticky_blank", 32'(overflow), 32'h1);

        // Over-long line: columns past H discarded, next line restarts at column 0.
        mon_q.delete();
        frame_begin();
        check("ovf_cleared_on_start", 32'(overflow), 32'h0);
        send_line(0, H + 10, -1, -1);
        send_line(1, 2, -1, -1);
        frame_end();
        check("long_px_count", 32'(mon_q.size()), 32'(H + 2));
        check("long_last_x", 32'(rec_at(H - 1).x), 32'(H - 1));
        check("long_next_xy", 32'({rec_at(H).x[15:0], rec_at(H).y[15:0]}), 32'h0000_0001);
        check("long_pattern", 32'(pattern_errs()), 32'h0);

        // Reset in the middle of a line.
        fd0 = n_fd;
        frame_begin();
        for (int y = 0; y < 3; y++) send_line(y, H, -1, -1);
        fork
            send_line(3, H, -1, -1);
            begin
                clk_n(22);
                reset = 1'b0;
                #1;
                check("midrst_zero", 32'({px_data, 3'b0, px_valid, 4'(px_x), 4'(px_y),
                      frame_start, frame_done, overflow, busy}), 32'h0);
            end
        join
        clk_n(4);
        check("midrst_no_done", 32'(n_fd - fd0), 32'h0);
        reset = 1'b1;
        mon_q.delete();
        send_line(4, H, -1, -1);
        check("midrst_no_capture_mid_frame", 32'(mon_q.size()), 32'h0);
        check("midrst_idle", 32'(busy), 32'h0);
        frame_end();
        check("midrst_rearmed", 32'(busy), 32'h1);
        frame_begin();
        send_line(0, 2, -1, -1);
        frame_end();
        check("midrst_px_count", 32'(mon_q.size()), 32'h2);
        check("midrst_first_xy", 32'({rec_at(0).x[15:0], rec_at(0).y[15:0]}), 32'h0);

        // Enable dropped mid-frame: frame finishes, then idle.
        mon_q.delete();
        fd0 = n_fd;
        frame_begin();
        send_line(0, H, -1, -1);
        enable = 1'b0;
        send_line(1, H, -1, -1);
        send_line(2, H, -1, -1);
        frame_end();
        check("endrop_px_count", 32'(mon_q.size()), 32'(3 * H));
        check("endrop_done", 32'(n_fd - fd0), 32'h1);
        check("endrop_idle", 32'(busy), 32'h0);
        mon_q.delete();
        frame_begin();
        send_line(0, H, -1, -1);
        frame_end();
        check("endrop_no_more_px", 32'(mon_q.size()), 32'h0);
        check("endrop_still_idle", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
